// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the IF/ID register layout used by fetch, decode
// and the hazard-unit bench.
package pipe_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: reset, execute redirect (forced word-aligned), stall hold, else PC+4.
// Updates on each rising edge; pcf is the flop output, pc_plus4f is combinational.
module pc_register #(
  parameter int                    DATA_WIDTH = pipe_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = pipe_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] pcf,
  output logic [DATA_WIDTH-1:0] pc_plus4f
);

  // Wraps naturally at 2^DATA_WIDTH.
  assign pc_plus4f = pcf + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf <= RESET_PC;
    end else if (redirect) begin
      pcf <= {target[DATA_WIDTH-1:2], 2'b00};
    end else if (!stall) begin
      pcf <= pc_plus4f;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, IF/ID register, sticky misalign flag and fetch counter.
// A redirect from execute always squashes the instruction currently in IF.
module fetch_stage #(
  parameter int                    DATA_WIDTH = pipe_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = pipe_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipe_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrF_i,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic                  StallF_i,
  input  logic                  StallD_i,
  input  logic                  FlushD_i,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] InstrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PCPlus4D_o,
  output logic                  ValidD_o,
  output logic                  MisalignF_o,
  output logic [31:0]           FetchCnt_o
);
  import pipe_pkg::*;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [DATA_WIDTH-1:0] pc_plus4f;
  logic                  flush_eff;
  logic                  load_d;
  if_id_t                if_id_q;

  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .redirect  (PCSrcE_i),
    .target    (PCTargetE_i),
    .stall     (StallF_i),
    .pcf       (PCF_o),
    .pc_plus4f (pc_plus4f)
  );

  assign flush_eff = FlushD_i | PCSrcE_i;
  assign load_d    = !flush_eff && !StallD_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q     <= IF_ID_BUBBLE;
      MisalignF_o <= 1'b0;
      FetchCnt_o  <= '0;
    end else begin
      if (flush_eff) begin
        if_id_q <= IF_ID_BUBBLE;
      end else if (!StallD_i) begin
        if_id_q <= '{instr: InstrF_i, pc: PCF_o, pc_plus4: pc_plus4f, valid: 1'b1};
      end
      // Sticky until reset so software/debug can see a bad target was ever taken.
      if (PCSrcE_i && (PCTargetE_i[1:0] != 2'b00)) begin
        MisalignF_o <= 1'b1;
      end
      if (load_d) begin
        FetchCnt_o <= FetchCnt_o + 32'd1;
      end
    end
  end

  assign InstrD_o   = if_id_q.instr;
  assign PCD_o      = if_id_q.pc;
  assign PCPlus4D_o = if_id_q.pc_plus4;
  assign ValidD_o   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal checks plus randomized run against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsrc = 1'b0;
  logic        stallf = 1'b0;
  logic        stalld = 1'b0;
  logic        flushd = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pcf, instr_d, pcd, pc4d, cnt;
  logic        valid_d, misalign;

  int tests = 0;
  int fails = 0;
  bit mem_mode = 1'b0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory: constant ADDI in directed mode, address hash in random mode.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit mode);
    if (!mode) return ADDI;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  assign instr_f = mem_word(pcf, mem_mode);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .InstrF_i    (instr_f),
    .PCSrcE_i    (pcsrc),
    .PCTargetE_i (target),
    .StallF_i    (stallf),
    .StallD_i    (stalld),
    .FlushD_i    (flushd),
    .PCF_o       (pcf),
    .InstrD_o    (instr_d),
    .PCD_o       (pcd),
    .PCPlus4D_o  (pc4d),
    .ValidD_o    (valid_d),
    .MisalignF_o (misalign),
    .FetchCnt_o  (cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what decode should see, derived from the fetch rules.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_vld, m_mis;

  always @(posedge clk) begin
    logic [31:0] fetched;
    fetched = mem_word(m_pc, mem_mode);
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0;
      m_vld = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else begin
      if (pcsrc || flushd) begin
        m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
      end else if (!stalld) begin
        m_instr = fetched; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_vld = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
      if (pcsrc) begin
        if (target % 4 != 0) m_mis = 1'b1;
        m_pc = target - (target % 4);
      end else if (!stallf) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pcf",      pcf,     m_pc);
      check("model_instr_d",  instr_d, m_instr);
      check("model_pcd",      pcd,     m_pcd);
      check("model_pc4d",     pc4d,    m_pc4);
      check("model_valid_d",  {31'b0, valid_d},  {31'b0, m_vld});
      check("model_misalign", {31'b0, misalign}, {31'b0, m_mis});
      check("model_cnt",      cnt,     m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_pcf", pcf, 32'h0);
    check("rst_instr", instr_d, NOP);
    check("rst_pcd", pcd, 32'h0);
    check("rst_valid", {31'b0, valid_d}, 32'h0);
    check("rst_cnt", cnt, 32'h0);
    check("rst_mis", {31'b0, misalign}, 32'h0);
    rst = 1'b0;

    // Free run
    cyc();
    check("run1_pcf", pcf, 32'h4);
    check("run1_instr", instr_d, ADDI);
    check("run1_pcd", pcd, 32'h0);
    check("run1_pc4d", pc4d, 32'h4);
    check("run1_valid", {31'b0, valid_d}, 32'h1);
    check("run1_cnt", cnt, 32'h1);
    cyc(); cyc();
    check("run3_pcf", pcf, 32'hC);
    check("run3_pcd", pcd, 32'h8);
    check("run3_cnt", cnt, 32'h3);

    // Aligned redirect
    pcsrc = 1'b1; target = 32'h40;
    cyc();
    pcsrc = 1'b0;
    check("redir_pcf", pcf, 32'h40);
    check("redir_instr", instr_d, NOP);
    check("redir_valid", {31'b0, valid_d}, 32'h0);
    check("redir_mis", {31'b0, misalign}, 32'h0);
    check("redir_cnt", cnt, 32'h3);
    cyc();
    check("tgt_pcd", pcd, 32'h40);
    check("tgt_valid", {31'b0, valid_d}, 32'h1);
    check("tgt_pcf", pcf, 32'h44);
    check("tgt_cnt", cnt, 32'h4);

    // Full stall at PC 0x10
    pcsrc = 1'b1; target = 32'h10;
    cyc();
    pcsrc = 1'b0;
    check("pre_stall_pcf", pcf, 32'h10);
    stallf = 1'b1; stalld = 1'b1;
    repeat (2) begin
      cyc();
      check("stall_pcf", pcf, 32'h10);
      check("stall_instr", instr_d, NOP);
      check("stall_pcd", pcd, 32'h0);
      check("stall_cnt", cnt, 32'h4);
    end
    stallf = 1'b0; stalld = 1'b0;
    cyc();
    check("resume_pcf", pcf, 32'h14);
    check("resume_pcd", pcd, 32'h10);
    check("resume_cnt", cnt, 32'h5);

    // Misaligned redirect beats stall
    pcsrc = 1'b1; stallf = 1'b1; target = 32'h102;
    cyc();
    pcsrc = 1'b0; stallf = 1'b0;
    check("mis_pcf", pcf, 32'h100);
    check("mis_flag", {31'b0, misalign}, 32'h1);
    check("mis_valid", {31'b0, valid_d}, 32'h0);
    repeat (3) cyc();
    check("mis_sticky", {31'b0, misalign}, 32'h1);
    check("mis_run_pcf", pcf, 32'h10C);
    check("mis_run_cnt", cnt, 32'h8);

    // PC wrap
    pcsrc = 1'b1; target = 32'hFFFF_FFFC;
    cyc();
    pcsrc = 1'b0;
    check("wrap_pre_pcf", pcf, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pcf", pcf, 32'h0);
    check("wrap_pcd", pcd, 32'hFFFF_FFFC);
    check("wrap_pc4d", pc4d, 32'h0);

    // Reset during stall with a pending redirect
    stallf = 1'b1; stalld = 1'b1; pcsrc = 1'b1; target = 32'h200; rst = 1'b1;
    cyc();
    check("midrst_pcf", pcf, 32'h0);
    check("midrst_instr", instr_d, NOP);
    check("midrst_valid", {31'b0, valid_d}, 32'h0);
    check("midrst_cnt", cnt, 32'h0);
    check("midrst_mis", {31'b0, misalign}, 32'h0);
    rst = 1'b0; pcsrc = 1'b0; stallf = 1'b0; stalld = 1'b0;

    // Randomized traffic against the model
    mem_mode = 1'b1;
    repeat (3000) begin
      rst    = ($urandom_range(0, 99) == 0);
      pcsrc  = ($urandom_range(0, 7) == 0);
      target = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
      stallf = ($urandom_range(0, 3) == 0);
      stalld = ($urandom_range(0, 3) == 0);
      flushd = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rst = 1'b0; pcsrc = 1'b0; stallf = 1'b0; stalld = 1'b0; flushd = 1'b0;
    cyc();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
